// File: rtl/axis_red_pitaya_dac.sv
// AXI4-Stream sink for the Red Pitaya dual-channel DAC: saturates signed 16-bit sample
// pairs to DAC width, converts them to offset-inverted DAC code and sequences DAC reset/settle.
module axis_red_pitaya_dac #(
    parameter int DAC_DATA_WIDTH    = 14,
    parameter int AXIS_TDATA_WIDTH  = 32,
    parameter int RST_CYCLES        = 16,
    parameter int SETTLE_CYCLES     = 64,
    parameter int HOLD_ON_UNDERFLOW = 1,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        enable,
    input  logic                        clear,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic [DAC_DATA_WIDTH-1:0]   dac_dat_a,
    output logic [DAC_DATA_WIDTH-1:0]   dac_dat_b,
    output logic                        dac_rst,
    output logic                        running,
    output logic [CNT_WIDTH-1:0]        underflow_cnt,
    output logic                        sat_a,
    output logic                        sat_b
);

    localparam int W    = DAC_DATA_WIDTH;
    localparam int SMAX = (2 ** (W - 1)) - 1;
    localparam int SMIN = -(2 ** (W - 1));
    localparam logic [W-1:0] IDLE_CODE = {1'b0, {(W - 1){1'b1}}};

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [31:0]          phase_cnt_r;
    logic                 transfer_s;
    logic                 underflow_s;
    logic [W-1:0]         dat_a_next_s;
    logic [W-1:0]         dat_b_next_s;
    logic [CNT_WIDTH-1:0] cnt_base_s;
    logic [CNT_WIDTH-1:0] cnt_next_s;

    function automatic logic is_clamped(input logic [15:0] x);
        int xi;
        xi = int'($signed(x));
        is_clamped = (xi > SMAX) || (xi < SMIN);
    endfunction

    // Code is the sign bit followed by the inverted magnitude bits, mirroring the ADC core.
    function automatic logic [W-1:0] to_code(input logic [15:0] x);
        int           xi;
        logic [W-1:0] s;
        xi = int'($signed(x));
        if (xi > SMAX) begin
            s = SMAX[W-1:0];
        end else if (xi < SMIN) begin
            s = SMIN[W-1:0];
        end else begin
            s = xi[W-1:0];
        end
        to_code = {s[W-1], ~s[W-2:0]};
    endfunction

    // Next-state decode of the reset/settle/run sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RST: begin
                if (phase_cnt_r == 32'(RST_CYCLES - 1)) begin
                    next_state_s = ST_SETTLE;
                end else begin
                    next_state_s = ST_RST;
                end
            end
            ST_SETTLE: begin
                if (phase_cnt_r == 32'(SETTLE_CYCLES - 1)) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_SETTLE;
                end
            end
            ST_RUN:  next_state_s = ST_RUN;
            default: next_state_s = ST_RST;
        endcase
    end

    // State register, phase counter and registered status decodes.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= ST_RST;
            phase_cnt_r <= 32'd0;
            dac_rst     <= 1'b1;
            running     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                phase_cnt_r <= 32'd0;
            end else if (state_r != ST_RUN) begin
                phase_cnt_r <= phase_cnt_r + 32'd1;
            end else begin
                phase_cnt_r <= phase_cnt_r;
            end
            dac_rst <= (next_state_s == ST_RST);
            running <= (next_state_s == ST_RUN);
        end
    end

    assign s_axis_tready = running & enable;
    assign transfer_s    = s_axis_tready & s_axis_tvalid;
    assign underflow_s   = s_axis_tready & ~s_axis_tvalid;

    // Output code selection and saturating underflow count; a new event beats clear.
    always_comb begin
        dat_a_next_s = IDLE_CODE;
        dat_b_next_s = IDLE_CODE;
        if (transfer_s) begin
            dat_a_next_s = to_code(s_axis_tdata[15:0]);
            dat_b_next_s = to_code(s_axis_tdata[31:16]);
        end else if (underflow_s && (HOLD_ON_UNDERFLOW != 0)) begin
            dat_a_next_s = dac_dat_a;
            dat_b_next_s = dac_dat_b;
        end else begin
            dat_a_next_s = IDLE_CODE;
            dat_b_next_s = IDLE_CODE;
        end

        cnt_base_s = clear ? {CNT_WIDTH{1'b0}} : underflow_cnt;
        if (underflow_s && (cnt_base_s != {CNT_WIDTH{1'b1}})) begin
            cnt_next_s = cnt_base_s + CNT_WIDTH'(1);
        end else begin
            cnt_next_s = cnt_base_s;
        end
    end

    // DAC output registers and sticky status.
    always_ff @(posedge aclk) begin
        if (areset) begin
            dac_dat_a     <= IDLE_CODE;
            dac_dat_b     <= IDLE_CODE;
            underflow_cnt <= {CNT_WIDTH{1'b0}};
            sat_a         <= 1'b0;
            sat_b         <= 1'b0;
        end else begin
            dac_dat_a     <= dat_a_next_s;
            dac_dat_b     <= dat_b_next_s;
            underflow_cnt <= cnt_next_s;
            sat_a         <= (transfer_s & is_clamped(s_axis_tdata[15:0]))  | (sat_a & ~clear);
            sat_b         <= (transfer_s & is_clamped(s_axis_tdata[31:16])) | (sat_b & ~clear);
        end
    end

endmodule

// File: tb/tb_axis_red_pitaya_dac.sv
// Directed bench for axis_red_pitaya_dac: default instance plus a short-sequence,
// zero-on-underflow, 4-bit-counter instance.
module tb_axis_red_pitaya_dac;

    logic        aclk;
    int          n_cmp;
    int          n_err;

    logic        areset, enable, clear, tvalid;
    logic [31:0] tdata;
    logic        tready, dac_rst, running, sat_a, sat_b;
    logic [13:0] dat_a, dat_b;
    logic [31:0] ucnt;

    logic        areset2, enable2, clear2, tvalid2;
    logic [31:0] tdata2;
    logic        tready2, dac_rst2, running2, sat_a2, sat_b2;
    logic [13:0] dat_a2, dat_b2;
    logic [3:0]  ucnt2;

    axis_red_pitaya_dac dut (
        .aclk(aclk), .areset(areset), .enable(enable), .clear(clear),
        .s_axis_tready(tready), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
        .dac_dat_a(dat_a), .dac_dat_b(dat_b), .dac_rst(dac_rst), .running(running),
        .underflow_cnt(ucnt), .sat_a(sat_a), .sat_b(sat_b)
    );

    axis_red_pitaya_dac #(
        .RST_CYCLES(2), .SETTLE_CYCLES(3), .HOLD_ON_UNDERFLOW(0), .CNT_WIDTH(4)
    ) dut2 (
        .aclk(aclk), .areset(areset2), .enable(enable2), .clear(clear2),
        .s_axis_tready(tready2), .s_axis_tvalid(tvalid2), .s_axis_tdata(tdata2),
        .dac_dat_a(dat_a2), .dac_dat_b(dat_b2), .dac_rst(dac_rst2), .running(running2),
        .underflow_cnt(ucnt2), .sat_a(sat_a2), .sat_b(sat_b2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        areset = 1'b1; enable = 1'b1; clear = 1'b0; tvalid = 1'b1; tdata = {16'd100, 16'd100};
        areset2 = 1'b1; enable2 = 1'b0; clear2 = 1'b0; tvalid2 = 1'b0; tdata2 = 32'd0;

        // reset state
        tick();
        chk("rst_dac_rst", {31'd0, dac_rst}, 32'd1);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_tready",  {31'd0, tready},  32'd0);
        chk("rst_dat_a",   {18'd0, dat_a},   32'h1FFF);
        chk("rst_dat_b",   {18'd0, dat_b},   32'h1FFF);
        chk("rst_cnt",     ucnt,             32'd0);
        chk("rst_sat",     {30'd0, sat_a, sat_b}, 32'd0);
        areset = 1'b0;

        // bring-up: 16 cycles dac_rst, 64 settle, RUN from cycle 81; nothing accepted before
        for (int i = 1; i <= 80; i++) begin
            tick();
            chk("seq_dac_rst", {31'd0, dac_rst}, (i < 16) ? 32'd1 : 32'd0);
            chk("seq_running", {31'd0, running}, (i >= 80) ? 32'd1 : 32'd0);
            chk("seq_dat_a",   {18'd0, dat_a},   32'h1FFF);
        end
        chk("run_tready", {31'd0, tready}, 32'd1);

        // first-RUN-cycle transfer, conversion of in-range values
        tdata = {16'd0, 16'd8191};
        tick();
        chk("conv1_a", {18'd0, dat_a}, 32'h0000);
        chk("conv1_b", {18'd0, dat_b}, 32'h1FFF);
        chk("conv1_sat", {30'd0, sat_a, sat_b}, 32'd0);
        tdata = {16'd100, 16'hE000};
        tick();
        chk("conv2_a", {18'd0, dat_a}, 32'h3FFF);
        chk("conv2_b", {18'd0, dat_b}, 32'h1F9B);
        chk("conv2_sat", {30'd0, sat_a, sat_b}, 32'd0);

        // saturation, sticky flags, clear vs event
        tdata = {16'h8000, 16'h7FFF};
        tick();
        chk("sat_a_code", {18'd0, dat_a}, 32'h0000);
        chk("sat_b_code", {18'd0, dat_b}, 32'h3FFF);
        chk("sat_flags",  {30'd0, sat_a, sat_b}, 32'd3);
        tdata = {16'd0, 16'd0};
        tick();
        chk("sat_sticky", {30'd0, sat_a, sat_b}, 32'd3);
        clear = 1'b1; tdata = {16'd0, 16'd9000};
        tick();
        chk("clr_vs_event", {30'd0, sat_a, sat_b}, 32'd2);
        tdata = {16'd0, 16'd0};
        tick();
        chk("clr_flags", {30'd0, sat_a, sat_b}, 32'd0);
        clear = 1'b0;

        // underflow with hold
        tdata = {16'd1, 16'hFFFF};
        tick();
        chk("neg1_a", {18'd0, dat_a}, 32'h2000);
        chk("pos1_b", {18'd0, dat_b}, 32'h1FFE);
        tvalid = 1'b0;
        #1;
        chk("tready_no_tvalid", {31'd0, tready}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("uf_hold_a", {18'd0, dat_a}, 32'h2000);
        chk("uf_hold_b", {18'd0, dat_b}, 32'h1FFE);
        chk("uf_cnt5",   ucnt, 32'd5);

        // enable low: idle outputs, no counting
        enable = 1'b0;
        #1;
        chk("dis_tready", {31'd0, tready}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("dis_dat_a", {18'd0, dat_a}, 32'h1FFF);
        chk("dis_dat_b", {18'd0, dat_b}, 32'h1FFF);
        chk("dis_cnt",   ucnt, 32'd5);
        enable = 1'b1; tvalid = 1'b1; tdata = {16'hFFFB, 16'd5};
        tick();
        chk("re_a", {18'd0, dat_a}, 32'h1FFA);
        chk("re_b", {18'd0, dat_b}, 32'h2004);
        tdata = {16'd0, 16'h7FFF};
        tick();
        chk("pre_rst_sat", {30'd0, sat_a, sat_b}, 32'd2);

        // areset mid-RUN
        areset = 1'b1;
        tick();
        chk("mid_rst_dac_rst", {31'd0, dac_rst}, 32'd1);
        chk("mid_rst_running", {31'd0, running}, 32'd0);
        chk("mid_rst_tready",  {31'd0, tready},  32'd0);
        chk("mid_rst_dat",     {4'd0, dat_a, dat_b}, {4'd0, 14'h1FFF, 14'h1FFF});
        chk("mid_rst_cnt",     ucnt, 32'd0);
        chk("mid_rst_sat",     {30'd0, sat_a, sat_b}, 32'd0);

        // second instance: short sequence, zero on underflow, 4-bit saturating counter
        enable2 = 1'b1; tvalid2 = 1'b1; tdata2 = {16'd0, 16'hFFFF};
        tick();
        areset2 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("d2_not_run", {31'd0, running2}, 32'd0);
        tick();
        chk("d2_run", {31'd0, running2}, 32'd1);
        tick();
        chk("d2_a", {18'd0, dat_a2}, 32'h2000);
        tvalid2 = 1'b0;
        tick();
        chk("d2_uf_idle_a", {18'd0, dat_a2}, 32'h1FFF);
        chk("d2_uf_idle_b", {18'd0, dat_b2}, 32'h1FFF);
        chk("d2_cnt1", {28'd0, ucnt2}, 32'd1);
        for (int i = 0; i < 19; i++) tick();
        chk("d2_cnt_sat", {28'd0, ucnt2}, 32'hF);
        clear2 = 1'b1;
        tick();
        chk("d2_clr_uf", {28'd0, ucnt2}, 32'd1);
        tvalid2 = 1'b1;
        tick();
        chk("d2_clr", {28'd0, ucnt2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
